io_port_bridge: RTL and testbench

- Buffers the CPU's single-word I/O port against an external host.
- Input direction: the host pushes 64-bit words into an input FIFO with a valid/ready handshake. The CPU consumes them through the in_signal/in_data pair.
- Output direction: the CPU's out_signal/out_data writes are captured into an output FIFO. The host drains that FIFO with valid/ready.
- Sits directly beside the CPU top level, outside the core. Connects to its in_signal, in_data, out_signal and out_data ports.

---
 rtl/io_pkg.sv | 19 +
 rtl/io_sync_fifo.sv | 64 ++++++
 rtl/io_port_bridge.sv | 170 +++++++++++++++++
 tb/tb_io_port_bridge.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/io_pkg.sv
// Shared definitions for the CPU I/O port bridge.
//   IO_DATA_W  : CPU I/O word width
//   rd_state_t : CPU read-strobe tracker states
//   wr_state_t : CPU write-strobe tracker states
package io_pkg;

  localparam int unsigned IO_DATA_W = 64;

  typedef enum logic {
    RD_IDLE,
    RD_ACTIVE
  } rd_state_t;

  typedef enum logic {
    WR_IDLE,
    WR_ACTIVE
  } wr_state_t;

endpackage

// File: rtl/io_sync_fifo.sv
// Show-ahead synchronous FIFO. The head word is visible combinationally.
// Ports:
//   clk, reset          : clock, asynchronous active-low reset
//   push, push_data     : write request and data (ignored when full)
//   pop                 : read request (ignored when empty)
//   head                : current head word (not meaningful when empty)
//   full, empty, count  : occupancy status
module io_sync_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 8,
  localparam int unsigned AW = $clog2(DEPTH),
  localparam int unsigned CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign head    = mem_q[rd_ptr_q];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_comb begin
    count_d = count_q;
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointers are exactly AW bits wide so they wrap on their own.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  // Storage needs no reset; empty/count qualify every read.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/io_port_bridge.sv
// Buffers the CPU's single-word I/O port against an external host.
// Ports:
//   clk, reset                         : clock, asynchronous active-low reset
//   cpu_in_signal, cpu_in_data         : CPU read strobe and word presented to it
//   cpu_out_signal, cpu_out_data       : CPU write strobe and its word
//   host_in_valid/ready/data           : host -> input FIFO handshake
//   host_out_valid/ready/data          : output FIFO -> host handshake
//   in_count, out_count                : FIFO occupancies
//   in_underflow, out_overflow         : sticky error flags
//   err_clear                          : synchronous clear of the sticky flags
module io_port_bridge
  import io_pkg::*;
#(
  parameter int unsigned DATA_W    = IO_DATA_W,
  parameter int unsigned IN_DEPTH  = 8,
  parameter int unsigned OUT_DEPTH = 8,
  localparam int unsigned IN_CW  = $clog2(IN_DEPTH + 1),
  localparam int unsigned OUT_CW = $clog2(OUT_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_in_signal,
  output logic [DATA_W-1:0] cpu_in_data,
  input  logic              cpu_out_signal,
  input  logic [DATA_W-1:0] cpu_out_data,
  input  logic              host_in_valid,
  output logic              host_in_ready,
  input  logic [DATA_W-1:0] host_in_data,
  output logic              host_out_valid,
  input  logic              host_out_ready,
  output logic [DATA_W-1:0] host_out_data,
  output logic [IN_CW-1:0]  in_count,
  output logic [OUT_CW-1:0] out_count,
  output logic              in_underflow,
  output logic              out_overflow,
  input  logic              err_clear
);

  rd_state_t rd_state_q, rd_state_d;
  wr_state_t wr_state_q, wr_state_d;
  logic      armed_q, armed_d;
  logic      init_q;
  logic      in_underflow_q, out_overflow_q;
  logic      rd_err_set, wr_err_set;

  logic              in_push, in_pop, in_full, in_empty;
  logic              out_push, out_pop, out_full, out_empty;
  logic [DATA_W-1:0] in_head, out_head;

  // init_q keeps host_in_ready low while in reset and rises on the first edge after release.
  assign host_in_ready  = init_q & ~in_full;
  assign in_push        = host_in_valid & host_in_ready;
  assign host_out_valid = ~out_empty;
  assign out_pop        = host_out_valid & host_out_ready;
  // Gate the head so stale storage never leaks out while the FIFO is empty.
  assign host_out_data  = out_empty ? '0 : out_head;
  assign in_underflow   = in_underflow_q;
  assign out_overflow   = out_overflow_q;

  io_sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (IN_DEPTH)
  ) u_in_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (in_push),
    .push_data (host_in_data),
    .pop       (in_pop),
    .head      (in_head),
    .full      (in_full),
    .empty     (in_empty),
    .count     (in_count)
  );

  io_sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (OUT_DEPTH)
  ) u_out_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (out_push),
    .push_data (cpu_out_data),
    .pop       (out_pop),
    .head      (out_head),
    .full      (out_full),
    .empty     (out_empty),
    .count     (out_count)
  );

  // State registers for both strobe trackers, the sticky flags and the init flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_state_q     <= RD_IDLE;
      armed_q        <= 1'b0;
      wr_state_q     <= WR_IDLE;
      init_q         <= 1'b0;
      in_underflow_q <= 1'b0;
      out_overflow_q <= 1'b0;
    end else begin
      rd_state_q     <= rd_state_d;
      armed_q        <= armed_d;
      wr_state_q     <= wr_state_d;
      init_q         <= 1'b1;
      // A new error in the same cycle as err_clear wins.
      in_underflow_q <= rd_err_set | (in_underflow_q & ~err_clear);
      out_overflow_q <= wr_err_set | (out_overflow_q & ~err_clear);
    end
  end

  // Read side next state. armed records whether a word was present when the strobe rose,
  // so the word shown to the CPU stays fixed for the whole strobe.
  always_comb begin
    rd_state_d = rd_state_q;
    armed_d    = armed_q;
    unique case (rd_state_q)
      RD_IDLE: begin
        if (cpu_in_signal) begin
          rd_state_d = RD_ACTIVE;
          armed_d    = ~in_empty;
        end
      end
      RD_ACTIVE: begin
        if (!cpu_in_signal) begin
          rd_state_d = RD_IDLE;
          armed_d    = 1'b0;
        end
      end
      default: rd_state_d = RD_IDLE;
    endcase
  end

  // Read side outputs: pop on the falling strobe edge only if armed.
  always_comb begin
    in_pop      = 1'b0;
    rd_err_set  = 1'b0;
    cpu_in_data = '0;
    unique case (rd_state_q)
      RD_IDLE: begin
        rd_err_set = cpu_in_signal & in_empty;
        if (!in_empty) cpu_in_data = in_head;
      end
      RD_ACTIVE: begin
        in_pop = ~cpu_in_signal & armed_q;
        if (armed_q) cpu_in_data = in_head;
      end
      default: cpu_in_data = '0;
    endcase
  end

  // Write side next state.
  always_comb begin
    wr_state_d = wr_state_q;
    unique case (wr_state_q)
      WR_IDLE:   if (cpu_out_signal) wr_state_d = WR_ACTIVE;
      WR_ACTIVE: if (!cpu_out_signal) wr_state_d = WR_IDLE;
      default:   wr_state_d = WR_IDLE;
    endcase
  end

  // Write side outputs: one push per strobe, on its rising edge.
  always_comb begin
    out_push   = 1'b0;
    wr_err_set = 1'b0;
    if (wr_state_q == WR_IDLE && cpu_out_signal) begin
      out_push   = ~out_full;
      wr_err_set = out_full;
    end
  end

endmodule

// File: tb/tb_io_port_bridge.sv
module tb_io_port_bridge;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_in_signal, cpu_out_signal;
  logic [63:0] cpu_in_data, cpu_out_data;
  logic        host_in_valid, host_in_ready;
  logic [63:0] host_in_data;
  logic        host_out_valid, host_out_ready;
  logic [63:0] host_out_data;
  logic [3:0]  in_count, out_count;
  logic        in_underflow, out_overflow, err_clear;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  io_port_bridge #(
    .DATA_W    (64),
    .IN_DEPTH  (8),
    .OUT_DEPTH (8)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .cpu_in_signal  (cpu_in_signal),
    .cpu_in_data    (cpu_in_data),
    .cpu_out_signal (cpu_out_signal),
    .cpu_out_data   (cpu_out_data),
    .host_in_valid  (host_in_valid),
    .host_in_ready  (host_in_ready),
    .host_in_data   (host_in_data),
    .host_out_valid (host_out_valid),
    .host_out_ready (host_out_ready),
    .host_out_data  (host_out_data),
    .in_count       (in_count),
    .out_count      (out_count),
    .in_underflow   (in_underflow),
    .out_overflow   (out_overflow),
    .err_clear      (err_clear)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  logic [63:0] q[$];
  int          mcount, sent, rcv, maxc;
  logic        phase, armed, do_push, do_pop;

  initial begin
    reset          = 1'b0;
    cpu_in_signal  = 1'b0;
    cpu_out_signal = 1'b0;
    cpu_out_data   = '0;
    host_in_valid  = 1'b1;
    host_in_data   = 64'h77;
    host_out_ready = 1'b0;
    err_clear      = 1'b0;

    // Reset held with host_in_valid asserted
    repeat (3) tick();
    chk("rst_in_ready", 64'(host_in_ready), 64'd0);
    chk("rst_in_count", 64'(in_count), 64'd0);
    chk("rst_cpu_in_data", cpu_in_data, 64'd0);
    chk("rst_out_valid", 64'(host_out_valid), 64'd0);
    chk("rst_out_data", host_out_data, 64'd0);
    chk("rst_underflow", 64'(in_underflow), 64'd0);
    reset         = 1'b1;
    host_in_valid = 1'b0;
    tick();
    chk("post_rst_in_ready", 64'(host_in_ready), 64'd1);
    chk("post_rst_in_count", 64'(in_count), 64'd0);

    // Input path
    host_in_valid = 1'b1;
    host_in_data  = 64'hA;
    tick();
    host_in_data = 64'hB;
    tick();
    host_in_valid = 1'b0;
    chk("in_count_2", 64'(in_count), 64'd2);
    chk("idle_head_A", cpu_in_data, 64'hA);
    cpu_in_signal = 1'b1;
    tick();
    chk("strobe1_A", cpu_in_data, 64'hA);
    tick();
    chk("strobe2_A", cpu_in_data, 64'hA);
    tick();
    chk("strobe3_A", cpu_in_data, 64'hA);
    chk("strobe3_count", 64'(in_count), 64'd2);
    cpu_in_signal = 1'b0;
    tick();
    chk("pop_A_count", 64'(in_count), 64'd1);
    chk("head_B", cpu_in_data, 64'hB);
    cpu_in_signal = 1'b1;
    tick();
    chk("strobe_B", cpu_in_data, 64'hB);
    cpu_in_signal = 1'b0;
    tick();
    chk("pop_B_count", 64'(in_count), 64'd0);
    chk("empty_data", cpu_in_data, 64'd0);
    chk("no_underflow", 64'(in_underflow), 64'd0);

    // Underflow and mid-strobe arrival
    cpu_in_signal = 1'b1;
    tick();
    chk("uf_flag", 64'(in_underflow), 64'd1);
    chk("uf_data", cpu_in_data, 64'd0);
    host_in_valid = 1'b1;
    host_in_data  = 64'hC;
    tick();
    host_in_valid = 1'b0;
    chk("uf_unarmed_data", cpu_in_data, 64'd0);
    cpu_in_signal = 1'b0;
    tick();
    chk("uf_retained", 64'(in_count), 64'd1);
    chk("uf_head_C", cpu_in_data, 64'hC);
    chk("uf_sticky", 64'(in_underflow), 64'd1);
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
    chk("uf_cleared", 64'(in_underflow), 64'd0);
    cpu_in_signal = 1'b1;
    tick();
    cpu_in_signal = 1'b0;
    tick();
    chk("drain_C", 64'(in_count), 64'd0);
    // New error with err_clear in the same cycle: set wins
    err_clear     = 1'b1;
    cpu_in_signal = 1'b1;
    tick();
    chk("set_wins", 64'(in_underflow), 64'd1);
    cpu_in_signal = 1'b0;
    tick();
    err_clear = 1'b0;
    chk("clear_after", 64'(in_underflow), 64'd0);

    // Output path: one push per strobe
    cpu_out_data   = 64'h55;
    cpu_out_signal = 1'b1;
    tick();
    tick();
    cpu_out_signal = 1'b0;
    tick();
    chk("out_one", 64'(out_count), 64'd1);
    chk("out_valid", 64'(host_out_valid), 64'd1);
    chk("out_data_55", host_out_data, 64'h55);
    host_out_ready = 1'b1;
    tick();
    host_out_ready = 1'b0;
    chk("out_popped_valid", 64'(host_out_valid), 64'd0);
    chk("out_popped_count", 64'(out_count), 64'd0);
    chk("out_empty_data", host_out_data, 64'd0);

    // Overflow: nine writes into an 8-deep FIFO
    for (int i = 1; i <= 9; i++) begin
      cpu_out_data   = 64'(i);
      cpu_out_signal = 1'b1;
      tick();
      cpu_out_signal = 1'b0;
      tick();
    end
    chk("ovf_count", 64'(out_count), 64'd8);
    chk("ovf_flag", 64'(out_overflow), 64'd1);
    host_out_ready = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      chk($sformatf("drain_%0d", k), host_out_data, 64'(k));
      tick();
    end
    host_out_ready = 1'b0;
    chk("drain_count", 64'(out_count), 64'd0);
    chk("drain_valid", 64'(host_out_valid), 64'd0);
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
    chk("ovf_cleared", 64'(out_overflow), 64'd0);

    // Concurrency and pointer wrap against a small queue model
    mcount = 0;
    sent   = 0;
    rcv    = 0;
    maxc   = 0;
    phase  = 1'b0;
    armed  = 1'b0;
    for (int cyc = 0; cyc < 200 && rcv < 20; cyc++) begin
      host_in_valid = (sent < 20);
      host_in_data  = 64'h100 + 64'(sent);
      cpu_in_signal = phase;
      #1;
      chk("cc_ready", 64'(host_in_ready), 64'(mcount < 8));
      chk("cc_count", 64'(in_count), 64'(mcount));
      if (!phase && armed) chk("cc_data", cpu_in_data, q[0]);
      do_push = host_in_valid && (mcount < 8);
      do_pop  = !phase && armed;
      if (phase) armed = (mcount > 0);
      else armed = 1'b0;
      if (do_pop) begin
        void'(q.pop_front());
        rcv++;
      end
      if (do_push) begin
        q.push_back(host_in_data);
        sent++;
      end
      mcount = q.size();
      if (mcount > maxc) maxc = mcount;
      @(posedge clk);
      #1;
      phase = ~phase;
    end
    host_in_valid = 1'b0;
    cpu_in_signal = 1'b0;
    chk("cc_all_read", 64'(rcv), 64'd20);
    chk("cc_max_le_8", 64'(maxc <= 8), 64'd1);
    tick();
    chk("cc_final_count", 64'(in_count), 64'd0);
    chk("cc_no_underflow", 64'(in_underflow), 64'd0);
    chk("cc_no_overflow", 64'(out_overflow), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
